div_fu_ctrl: RTL and testbench
==============================

DIV_FU_CTRL -- requirements
Module: div_fu_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 7: divider iteration count, equal to the sequential divider's num_cyc setting.
REQ-002 SHALL have parameter ROB_IDX_W, default 5: ROB tag width.
REQ-003 SHALL have parameter PREG_W, default 6: physical destination register tag width.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have these request ports:
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request
- req_funct3  in  3  100 div, 101 divu, 110 rem, 111 remu
- req_rs1_v  in  32  dividend
- req_rs2_v  in  32  divisor
- req_rob_idx  in  ROB_IDX_W  request ROB tag
- req_pd  in  PREG_W  request destination register tag
REQ-006 SHALL have flush  in  1: squash the in-flight operation.
REQ-007 SHALL have these divider ports:
- div_start  out  1  start pulse
- div_a  out  33  divider dividend
- div_b  out  33  divider divisor
- div_complete  in  1  divider done
- div_quotient  in  33  divider quotient
- div_remainder  in  33  divider remainder
REQ-008 SHALL have these response ports:
- resp_valid  out  1  result present
- resp_ready  in  1  result consumed
- resp_data  out  32  result value
- resp_rob_idx  out  ROB_IDX_W  response ROB tag
- resp_pd  out  PREG_W  response destination register tag

Function
REQ-009 SHALL implement states IDLE, START, BUSY, DONE.
REQ-010 SHALL drive req_ready = (state==IDLE) && !flush && !rst; a request is accepted on req_valid && req_ready.
REQ-011 SHALL, on acceptance, register funct3, rs1, rs2, rob_idx and pd.
REQ-012 SHALL form div_a and div_b by sign-extension of rs1/rs2 to 33 bits for div/rem, zero-extension for divu/remu.
REQ-013 SHALL, on acceptance, go IDLE->DONE (bypass, no div_start) when rs2==0.
- div/divu: result 0xFFFFFFFF.
- rem/remu: result rs1.
REQ-014 SHALL, on acceptance, go IDLE->DONE (bypass, no div_start) for signed overflow: div or rem with rs1=0x80000000 and rs2=0xFFFFFFFF.
- div: result 0x80000000.
- rem: result 0.
REQ-015 SHALL otherwise go IDLE->START on acceptance.
REQ-016 SHALL, in START, assert div_start for exactly one cycle, clear the cycle counter, and go to BUSY.
REQ-017 SHALL, in BUSY, increment the cycle counter (saturating at DIV_CYCLES-1) every cycle.
REQ-018 SHALL, in BUSY, ignore div_complete until the counter equals DIV_CYCLES-1; when counter==DIV_CYCLES-1 && div_complete, capture the result and go to DONE; otherwise remain in BUSY.
REQ-019 SHALL set the captured result to div_quotient[31:0] for div/divu and div_remainder[31:0] for rem/remu.
REQ-020 SHALL give non-bypass latency: accept at edge T, resp_valid high from cycle T+2+DIV_CYCLES when the divider completes on time; bypass latency: resp_valid high in cycle T+1.
REQ-021 SHALL, in DONE, hold resp_valid=1 with resp_data, resp_rob_idx and resp_pd stable until resp_ready; go DONE->IDLE on resp_valid && resp_ready.
REQ-022 SHALL keep at most one operation in flight; req_ready=0 in START, BUSY and DONE.
REQ-023 SHALL drive div_start=0 in all states except START.
REQ-024 SHALL, on flush, move any state to IDLE at the next edge, with resp_valid=0 from that cycle and no request accepted in the flush cycle.
REQ-025 SHALL accept a new request in the cycle after a flush, including a flush during BUSY; the subsequent div_start restarts the divider and no stale result is captured, because the counter is cleared in START.
REQ-026 SHALL give flush priority over resp_ready when both arrive in DONE; the result is dropped.
REQ-027 SHALL hold div_a and div_b stable from START through BUSY.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, counter 0, and all registered fields 0.
REQ-029 SHALL hold all outputs at 0 during reset: req_ready=0, div_start=0, resp_valid=0, resp_data=0, resp_rob_idx=0, resp_pd=0, div_a=0, div_b=0.
REQ-030 SHALL abandon any operation when rst asserts mid-operation; req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-031 SHALL cover: div rs1=0xFFFFFFF9 (-7), rs2=2 -> one div_start pulse, div_a=0x1FFFFFFF9, resp_data=0xFFFFFFFD (-3) at T+9, rob/pd tags echoed.
REQ-032 SHALL cover: remu rs1=0xFFFFFFF9, rs2=2 -> div_a=0x0FFFFFFF9, resp_data=1.
REQ-033 SHALL cover: divu rs1=5, rs2=0 -> no div_start, resp_data=0xFFFFFFFF at T+1; rem 5/0 -> resp_data=5.
REQ-034 SHALL cover: div 0x80000000/0xFFFFFFFF -> resp_data=0x80000000 with no div_start; rem -> 0.
REQ-035 SHALL cover: resp_ready held low 10 cycles in DONE -> resp_valid and data stable, req_ready=0 throughout.
REQ-036 SHALL cover: flush in BUSY counter=3, new divu 100/7 next cycle -> resp_data=14, exactly one response.

Source files
------------

// File: rtl/div_fu_ctrl.sv
// Issue-side controller for a sequential 33-bit divider: accepts one RISC-V
// div/divu/rem/remu op, bypasses divide-by-zero and signed overflow, returns the result.
module div_fu_ctrl #(
  parameter int unsigned DIV_CYCLES = 7,
  parameter int unsigned ROB_IDX_W  = 5,
  parameter int unsigned PREG_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_rs1_v,
  input  logic [31:0]          req_rs2_v,
  input  logic [ROB_IDX_W-1:0] req_rob_idx,
  input  logic [PREG_W-1:0]    req_pd,

  input  logic                 flush,

  output logic                 div_start,
  output logic [32:0]          div_a,
  output logic [32:0]          div_b,
  input  logic                 div_complete,
  input  logic [32:0]          div_quotient,
  input  logic [32:0]          div_remainder,

  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [ROB_IDX_W-1:0] resp_rob_idx,
  output logic [PREG_W-1:0]    resp_pd
);

  localparam int unsigned CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [31:0]            rs1_q, rs1_d;
  logic [31:0]            rs2_q, rs2_d;
  logic [ROB_IDX_W-1:0]   rob_q, rob_d;
  logic [PREG_W-1:0]      pd_q, pd_d;
  logic [31:0]            result_q, result_d;

  logic accept;
  logic req_div0;
  logic req_ovf;
  logic unused_bits;

  // funct3[0] selects unsigned, funct3[1] selects remainder
  assign req_ready = (state_q == IDLE) && !flush && !rst;
  assign accept    = req_valid && req_ready;
  assign req_div0  = (req_rs2_v == 32'd0);
  assign req_ovf   = !req_funct3[0] && (req_rs1_v == INT_MIN) && (req_rs2_v == ALL_ONES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rob_q    <= '0;
      pd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rob_q    <= rob_d;
      pd_q     <= pd_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath capture; flush overrides every transition
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rob_d    = rob_q;
    pd_d     = pd_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          funct3_d = req_funct3;
          rs1_d    = req_rs1_v;
          rs2_d    = req_rs2_v;
          rob_d    = req_rob_idx;
          pd_d     = req_pd;
          if (req_div0) begin
            result_d = req_funct3[1] ? req_rs1_v : ALL_ONES;
            state_d  = DONE;
          end else if (req_ovf) begin
            result_d = req_funct3[1] ? 32'd0 : INT_MIN;
            state_d  = DONE;
          end else begin
            state_d  = START;
          end
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if ((cnt_q == CNT_LAST) && div_complete) begin
          result_d = funct3_q[1] ? div_remainder[31:0] : div_quotient[31:0];
          state_d  = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
    end
  end

  assign div_start    = (state_q == START);
  assign div_a        = {funct3_q[0] ? 1'b0 : rs1_q[31], rs1_q};
  assign div_b        = {funct3_q[0] ? 1'b0 : rs2_q[31], rs2_q};
  assign resp_valid   = (state_q == DONE);
  assign resp_data    = result_q;
  assign resp_rob_idx = rob_q;
  assign resp_pd      = pd_q;

  assign unused_bits = ^{funct3_q[2], div_quotient[32], div_remainder[32]};

endmodule

// File: tb/tb_div_fu_ctrl.sv
// Scoreboard bench for div_fu_ctrl with a behavioural sequential-divider model.
`timescale 1ns/1ps
module tb_div_fu_ctrl;

  localparam int DIV_CYCLES = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1_v, req_rs2_v;
  logic [4:0]  req_rob_idx;
  logic [5:0]  req_pd;
  logic        flush;
  logic        div_start;
  logic [32:0] div_a, div_b;
  logic        div_complete;
  logic [32:0] div_quotient, div_remainder;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rob_idx;
  logic [5:0]  resp_pd;

  div_fu_ctrl #(.DIV_CYCLES(DIV_CYCLES), .ROB_IDX_W(5), .PREG_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1_v(req_rs1_v), .req_rs2_v(req_rs2_v), .req_rob_idx(req_rob_idx), .req_pd(req_pd),
    .flush(flush),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_complete(div_complete),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rob_idx(resp_rob_idx), .resp_pd(resp_pd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rob;
    logic [5:0]  pd;
    int          exp_cyc;
    int          base;
    int          exp_starts;
    logic [32:0] exp_a;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int first_cyc = 0;
  bit prev_valid = 1'b0;
  logic [32:0] last_a = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: raises complete early and holds it, so the controller must wait for its counter
  int m_cnt;
  bit m_busy;
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; div_complete <= 1'b0; m_cnt <= 0;
      div_quotient <= '0; div_remainder <= '0;
    end else if (div_start) begin
      m_busy <= 1'b1; div_complete <= 1'b0; m_cnt <= 0;
      div_quotient  <= 33'($signed(div_a) / $signed(div_b));
      div_remainder <= 33'($signed(div_a) % $signed(div_b));
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt >= 2) div_complete <= 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks holds during stalls
  always @(negedge clk) begin
    if (div_start) begin
      start_cnt = start_cnt + 1;
      last_a = div_a;
    end
    if (resp_valid && !prev_valid) first_cyc = cyc;
    prev_valid = resp_valid;
    if (resp_valid && !flush && !rst) begin
      if (sb.size() == 0) begin
        if (resp_ready) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: got data 0x%0h expected no response", resp_data);
        end
      end else if (!resp_ready) begin
        chk("stall_data", 64'(resp_data), 64'(sb[0].data));
        chk("stall_req_ready", 64'(req_ready), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", 64'(resp_data), 64'(e.data));
        chk("resp_rob", 64'(resp_rob_idx), 64'(e.rob));
        chk("resp_pd", 64'(resp_pd), 64'(e.pd));
        chk("latency", 64'(first_cyc), 64'(e.exp_cyc));
        chk("start_pulses", 64'(start_cnt - e.base), 64'(e.exp_starts));
        if (e.exp_starts == 1) chk("div_a", 64'(last_a), 64'(e.exp_a));
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rob, input logic [5:0] pd, input bit push,
                       input logic [31:0] exp_data, input bit bypass, input logic [32:0] exp_a);
    int g = 0;
    exp_t e;
    while (!req_ready && g < 200) begin @(negedge clk); g++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: got req_ready 0 expected 1");
      return;
    end
    if (push) begin
      e.data = exp_data; e.rob = rob; e.pd = pd;
      e.exp_cyc = cyc + 1 + (bypass ? 0 : DIV_CYCLES + 1);
      e.base = start_cnt; e.exp_starts = bypass ? 0 : 1; e.exp_a = exp_a;
      sb.push_back(e);
    end
    req_valid = 1'b1; req_funct3 = f3; req_rs1_v = a; req_rs2_v = b;
    req_rob_idx = rob; req_pd = pd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 300) begin @(negedge clk); g++; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_div_start"}, 64'(div_start), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_data"}, 64'(resp_data), 64'd0);
    chk({tag, "_resp_rob"}, 64'(resp_rob_idx), 64'd0);
    chk({tag, "_resp_pd"}, 64'(resp_pd), 64'd0);
    chk({tag, "_div_a"}, 64'(div_a), 64'd0);
    chk({tag, "_div_b"}, 64'(div_b), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_rs1_v = '0; req_rs2_v = '0;
    req_rob_idx = '0; req_pd = '0; flush = 1'b0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 64'(req_ready), 64'd1);

    // Normal divides and remainders
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'h0A, 6'h21, 1, 32'hFFFF_FFFD, 0, 33'h1_FFFF_FFF9);
    issue(3'b111, 32'hFFFF_FFF9, 32'd2, 5'h0B, 6'h22, 1, 32'h0000_0001, 0, 33'h0_FFFF_FFF9);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'h0C, 6'h23, 1, 32'hFFFF_FFFF, 0, 33'h1_FFFF_FFF9);
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0D, 6'h24, 1, 32'h0000_0000, 0, 33'h0_8000_0000);
    issue(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0E, 6'h25, 1, 32'h8000_0000, 0, 33'h0_8000_0000);
    // Bypass cases: divide by zero and signed overflow
    issue(3'b101, 32'd5, 32'd0, 5'h10, 6'h30, 1, 32'hFFFF_FFFF, 1, '0);
    issue(3'b110, 32'd5, 32'd0, 5'h11, 6'h31, 1, 32'h0000_0005, 1, '0);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'h12, 6'h32, 1, 32'h8000_0000, 1, '0);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'h13, 6'h33, 1, 32'h0000_0000, 1, '0);
    drain();

    // Back-pressure: resp_ready low for 10 cycles in DONE
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    issue(3'b100, 32'd20, 32'hFFFF_FFFD, 5'h14, 6'h34, 1, 32'hFFFF_FFFA, 0, 33'h0_0000_0014);
    g = 0;
    while (!resp_valid && g < 100) begin @(negedge clk); g++; end
    chk("stall_reached_done", 64'(resp_valid), 64'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    drain();

    // Flush while BUSY with counter at 3, then a new op in the next cycle
    issue(3'b101, 32'd1000, 32'd3, 5'h15, 6'h35, 0, '0, 0, '0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_valid", 64'(resp_valid), 64'd0);
    chk("flush_busy_ready", 64'(req_ready), 64'd1);
    issue(3'b101, 32'd100, 32'd7, 5'h16, 6'h36, 1, 32'd14, 0, 33'h0_0000_0064);
    drain();

    // Flush arriving together with resp_ready in DONE drops the result
    req_valid = 1'b1; req_funct3 = 3'b101; req_rs1_v = 32'd9; req_rs2_v = 32'd0;
    req_rob_idx = 5'h17; req_pd = 6'h37;
    @(posedge clk); #1 flush = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_done_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_done_valid", 64'(resp_valid), 64'd0);

    // Reset mid-operation, then recovery
    issue(3'b100, 32'd1000, 32'd3, 5'h18, 6'h38, 0, '0, 0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midop_reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midop_reset_ready", 64'(req_ready), 64'd1);
    issue(3'b100, 32'd100, 32'd7, 5'h19, 6'h39, 1, 32'd14, 0, 33'h0_0000_0064);
    drain();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
